// File: rtl/pipe_perf_monitor.sv
// pipe_perf_monitor: pipeline event counters for the 5-stage core.
// Counts cycles, stalls, flushes and retirements while in RUN, freezes at a
// cycle limit, and exposes an atomically captured shadow copy of the counters.
// Optional build macro: PERF_WRAP_EN (counters wrap and raise sticky ovf_o
// bits; otherwise counters saturate and ovf_o is tied low).
module pipe_perf_monitor #(
    parameter int CNT_W       = 32,
    parameter int CYCLE_LIMIT = 30   // 0 = unlimited
) (
    input  logic             clk_i,
    input  logic             rst_i,     // asynchronous, active-low
    input  logic             start_i,
    input  logic             stall_i,
    input  logic             jump_i,
    input  logic             branch_i,
    input  logic             br_eq_i,
    input  logic             retire_i,
    input  logic             clear_i,
    input  logic             snap_i,
    input  logic [1:0]       sel_i,
    output logic [CNT_W-1:0] rd_data_o,
    output logic             running_o,
    output logic             done_o,
    output logic [3:0]       ovf_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FROZEN = 2'd2
    } state_t;

    // Counter slot order matches sel_i and the ovf_o bit order.
    localparam int IDX_CYCLE  = 0;
    localparam int IDX_STALL  = 1;
    localparam int IDX_FLUSH  = 2;
    localparam int IDX_RETIRE = 3;

    // Comparison width large enough for both the counter and the limit.
    localparam int LIM_W = (CNT_W > 32) ? CNT_W : 32;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0][CNT_W-1:0] r_live;
    logic [3:0][CNT_W-1:0] r_shadow;
    logic [3:0][CNT_W-1:0] w_live_nxt;
    logic [3:0]            w_evt;
    logic [3:0]            w_wrap;
    logic                  w_count_en;
    logic                  w_limit_hit;
    logic [LIM_W-1:0]      w_cyc_ext;

    // Counting happens only on RUN edges; a clear on the same edge wins.
    assign w_count_en = (r_state == ST_RUN) && !clear_i;

    // Per-counter event strobes; a stall alongside a jump/branch is not a stall.
    always_comb begin
        w_evt = 4'b0000;
        if (w_count_en) begin
            w_evt[IDX_CYCLE]  = 1'b1;
            w_evt[IDX_STALL]  = stall_i & ~jump_i & ~branch_i;
            w_evt[IDX_FLUSH]  = jump_i | (branch_i & br_eq_i);
            w_evt[IDX_RETIRE] = retire_i;
        end
    end

    // Next counter values: wrap or saturate at all-ones depending on build.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_live_nxt = r_live;
        w_wrap     = 4'b0000;
        for (int i = 0; i < 4; i++) begin
`ifdef PERF_WRAP_EN
            if (w_evt[i]) begin
                w_live_nxt[i] = r_live[i] + CNT_W'(1);
                w_wrap[i]     = &r_live[i];
            end
`else
            if (w_evt[i] && !(&r_live[i])) begin
                w_live_nxt[i] = r_live[i] + CNT_W'(1);
            end
`endif
        end
    end

    // Limit is reached on the edge whose increment makes cycle equal CYCLE_LIMIT.
    assign w_cyc_ext   = LIM_W'(w_live_nxt[IDX_CYCLE]);
    assign w_limit_hit = (CYCLE_LIMIT != 0) && w_evt[IDX_CYCLE] &&
                         (w_cyc_ext == LIM_W'(CYCLE_LIMIT));

    // Next-state logic: clear dominates, FROZEN is left only through clear.
    always_comb begin
        w_state_nxt = r_state;
        if (clear_i) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   if (start_i) w_state_nxt = ST_RUN;
                ST_RUN: begin
                    if (w_limit_hit)   w_state_nxt = ST_FROZEN;
                    else if (!start_i) w_state_nxt = ST_IDLE;
                end
                ST_FROZEN: w_state_nxt = ST_FROZEN;
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!rst_i) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Live counters: cleared by clear_i, otherwise take the computed next value.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)       r_live <= '0;
        else if (clear_i) r_live <= '0;
        else              r_live <= w_live_nxt;
    end

    // Shadow set captures pre-increment, pre-clear live values on snap_i.
    always_ff @(posedge clk_i or negedge rst_i) begin
        // NOTE: the shadow set is flops, not a RAM, so it is reset like any other register.
        if (!rst_i)      r_shadow <= '0;
        else if (snap_i) r_shadow <= r_live;
    end

`ifdef PERF_WRAP_EN
    logic [3:0] r_ovf;

    // Sticky overflow flags, set on a wrap edge and dropped only by clear/reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)       r_ovf <= 4'b0000;
        else if (clear_i) r_ovf <= 4'b0000;
        else              r_ovf <= r_ovf | w_wrap;
    end

    assign ovf_o = r_ovf;
`else
    logic w_unused_wrap;
    assign w_unused_wrap = |w_wrap;
    assign ovf_o         = 4'b0000;
`endif

    assign rd_data_o = r_shadow[sel_i];
    assign running_o = (r_state == ST_RUN);
    assign done_o    = (r_state == ST_FROZEN);

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Directed bench for pipe_perf_monitor: a 32-bit instance with CYCLE_LIMIT=30
// and a 4-bit instance sharing the same stimulus for the overflow behaviour.
module tb_pipe_perf_monitor;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i, stall_i, jump_i, branch_i, br_eq_i, retire_i;
    logic        clear_i, snap_i;
    logic [1:0]  sel_i;
    logic [31:0] rd32;
    logic        run32, done32;
    logic [3:0]  ovf32;
    logic [3:0]  rd4;
    logic        run4, done4;
    logic [3:0]  ovf4;

    int total = 0;
    int bad   = 0;

    pipe_perf_monitor #(.CNT_W(32), .CYCLE_LIMIT(30)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i),
        .jump_i(jump_i), .branch_i(branch_i), .br_eq_i(br_eq_i),
        .retire_i(retire_i), .clear_i(clear_i), .snap_i(snap_i), .sel_i(sel_i),
        .rd_data_o(rd32), .running_o(run32), .done_o(done32), .ovf_o(ovf32)
    );

    pipe_perf_monitor #(.CNT_W(4), .CYCLE_LIMIT(30)) u_dut4 (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i),
        .jump_i(jump_i), .branch_i(branch_i), .br_eq_i(br_eq_i),
        .retire_i(retire_i), .clear_i(clear_i), .snap_i(snap_i), .sel_i(sel_i),
        .rd_data_o(rd4), .running_o(run4), .done_o(done4), .ovf_o(ovf4)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Select a shadow slot and check both instances' read data.
    task automatic rd(input logic [1:0] s, input logic [31:0] exp32,
                      input logic [31:0] exp4, input string tag);
        sel_i = s;
        #1;
        check({tag, "_32"}, rd32, exp32);
        if (exp4 != 32'hFFFF_FFFF) check({tag, "_4"}, {28'd0, rd4}, exp4);
    endtask

    task automatic snap();
        snap_i = 1'b1;
        tick();
        snap_i = 1'b0;
    endtask

    localparam logic [31:0] SKIP = 32'hFFFF_FFFF;

    initial begin
        rst_i = 1'b0; start_i = 1'b0; stall_i = 1'b0; jump_i = 1'b0;
        branch_i = 1'b0; br_eq_i = 1'b0; retire_i = 1'b0;
        clear_i = 1'b0; snap_i = 1'b0; sel_i = 2'd0;

        // Reset state.
        ticks(3);
        for (int s = 0; s < 4; s++) rd(2'(s), 32'd0, 32'd0, "reset_rd");
        check("reset_running", {31'd0, run32}, 32'd0);
        check("reset_done",    {31'd0, done32}, 32'd0);
        check("reset_ovf",     {28'd0, ovf32}, 32'd0);
        check("reset_ovf4",    {28'd0, ovf4}, 32'd0);

        // Release, start at edge 1, ten quiet RUN edges, then snapshot.
        rst_i = 1'b1;
        tick();
        check("idle_after_release", {31'd0, run32}, 32'd0);
        start_i = 1'b1;
        tick();
        check("run_entered", {31'd0, run32}, 32'd1);
        ticks(10);
        snap();                                   // live cycle now 11
        rd(2'd0, 32'd10, 32'd10, "snap10_cycle");
        rd(2'd1, 32'd0,  32'd0,  "snap10_stall");
        rd(2'd2, 32'd0,  32'd0,  "snap10_flush");
        rd(2'd3, 32'd0,  32'd0,  "snap10_retire");

        // Three plain stalls, stall+jump (flush only), untaken branch (nothing).
        stall_i = 1'b1;
        ticks(3);
        jump_i = 1'b1;
        tick();
        stall_i = 1'b0; jump_i = 1'b0; branch_i = 1'b1; br_eq_i = 1'b0;
        tick();
        branch_i = 1'b0;
        snap();                                   // live cycle now 17
        rd(2'd0, 32'd16, SKIP, "hz_cycle");
        rd(2'd1, 32'd3,  32'd3, "hz_stall");
        rd(2'd2, 32'd1,  32'd1, "hz_flush");
        rd(2'd3, 32'd0,  32'd0, "hz_retire");

        // Stall during taken branch is a flush; retire counts independently.
        stall_i = 1'b1; branch_i = 1'b1; br_eq_i = 1'b1; retire_i = 1'b1;
        tick();
        branch_i = 1'b0; br_eq_i = 1'b0;
        tick();
        stall_i = 1'b0; retire_i = 1'b0;
        snap();                                   // live cycle now 20
        rd(2'd0, 32'd19, SKIP, "mix_cycle");
        rd(2'd1, 32'd4,  32'd4, "mix_stall");
        rd(2'd2, 32'd2,  32'd2, "mix_flush");
        rd(2'd3, 32'd2,  32'd2, "mix_retire");

        // Run limit: ten more edges reach cycle=30 and freeze.
        ticks(9);
        check("pre_limit_running", {31'd0, run32}, 32'd1);
        check("pre_limit_done",    {31'd0, done32}, 32'd0);
        tick();
        check("limit_done",    {31'd0, done32}, 32'd1);
        check("limit_running", {31'd0, run32}, 32'd0);
        // Events and start toggling are ignored while frozen.
        stall_i = 1'b1; retire_i = 1'b1; jump_i = 1'b0;
        start_i = 1'b0;
        tick();
        start_i = 1'b1;
        ticks(2);
        stall_i = 1'b0; retire_i = 1'b0;
        check("frozen_sticky", {31'd0, done32}, 32'd1);
        snap();
        rd(2'd0, 32'd30, SKIP, "frozen_cycle");
        rd(2'd1, 32'd4,  SKIP, "frozen_stall");
        rd(2'd3, 32'd2,  SKIP, "frozen_retire");

        // Clear beats start on the same edge.
        clear_i = 1'b1; start_i = 1'b1;
        tick();
        clear_i = 1'b0;
        check("clear_idle_run",  {31'd0, run32}, 32'd0);
        check("clear_idle_done", {31'd0, done32}, 32'd0);
        tick();
        check("rerun_after_clear", {31'd0, run32}, 32'd1);
        ticks(12);
        // Clear and snap together at cycle=12.
        clear_i = 1'b1; snap_i = 1'b1;
        tick();
        clear_i = 1'b0; snap_i = 1'b0; start_i = 1'b0;
        rd(2'd0, 32'd12, SKIP, "clrsnap_cycle");
        check("clrsnap_idle", {31'd0, run32}, 32'd0);
        tick();
        snap();
        rd(2'd0, 32'd0, 32'd0, "post_clear_cycle");
        check("post_clear_idle", {31'd0, run32}, 32'd0);

        // Twenty retires: 4-bit instance saturates or wraps depending on build.
        start_i = 1'b1;
        tick();
        retire_i = 1'b1;
        ticks(20);
        retire_i = 1'b0;
        snap();
        check("ret20_run4_not_frozen", {31'd0, done4}, 32'd0);
`ifdef PERF_WRAP_EN
        rd(2'd3, 32'd20, 32'd4, "ret20_retire");
        rd(2'd0, 32'd20, 32'd4, "ret20_cycle");
        check("ret20_ovf4",   {28'd0, ovf4}, 32'd9);
        check("ret20_ovf4_3", {31'd0, ovf4[3]}, 32'd1);
`else
        rd(2'd3, 32'd20, 32'd15, "ret20_retire");
        rd(2'd0, 32'd20, 32'd15, "ret20_cycle");
        check("ret20_ovf4", {28'd0, ovf4}, 32'd0);
`endif
        check("ret20_ovf32", {28'd0, ovf32}, 32'd0);

        // Asynchronous reset between edges while running.
        check("pre_reset_running", {31'd0, run32}, 32'd1);
        #2;
        rst_i = 1'b0;
        #1;
        check("async_running", {31'd0, run32}, 32'd0);
        check("async_done",    {31'd0, done32}, 32'd0);
        check("async_ovf4",    {28'd0, ovf4}, 32'd0);
        for (int s = 0; s < 4; s++) rd(2'(s), 32'd0, 32'd0, "async_rd");
        start_i = 1'b0;
        tick();
        rst_i = 1'b1;
        tick();
        check("post_reset_idle", {31'd0, run32}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
